// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, constants and PC helper for the fetch stage
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // FSM encoding kept as plain constants so older flows can consume it.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE    = 2'd0;
    localparam fetch_state_t ST_WAIT    = 2'd1;
    localparam fetch_state_t ST_HOLD    = 2'd2;
    localparam fetch_state_t ST_DISCARD = 2'd3;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

    // Word-address increment; wraps 32'hFFFF_FFFF -> 0.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - fetched / discarded instruction event counters
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   fetched_inc         one instruction accepted into output or hold register
//   discarded_inc[1:0]  number of responses / valid entries thrown away this cycle
//   perf_fetched        running fetched count (wraps modulo 2^32)
//   perf_discarded      running discarded count (wraps modulo 2^32)
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            fetched_inc,
    input  logic [1:0]      discarded_inc,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_discarded
);

    logic [XLEN-1:0] fetched_q, fetched_d;
    logic [XLEN-1:0] discarded_q, discarded_d;

    always_comb begin
        fetched_d   = fetched_q + {{(XLEN-1){1'b0}}, fetched_inc};
        discarded_d = discarded_q + {{(XLEN-2){1'b0}}, discarded_inc};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            fetched_q   <= fetched_d;
            discarded_q <= discarded_d;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_discarded = discarded_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with hold buffer and redirect handling
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched / perf_discarded outputs).
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   stall_in                      F/D latch holding; registered outputs must not change
//   redirect_valid, redirect_pc   taken branch/jump from execute and its target
//   imem_req, imem_addr           registered single-cycle request pulse and word address
//   imem_rvalid, imem_rdata       one response per request, at least one cycle later
//   pc_out, ir_out, valid_out     {PC+1, instruction or NOP, real-instruction flag} to F/D
module fetch_stage
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_discarded,
`endif
    input  logic            stall_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] ir_out,
    output logic            valid_out
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] ir_out_q, ir_out_d;
    logic            valid_out_q, valid_out_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_ir_q, hold_ir_d;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_next(pc_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        pc_out_d    = pc_out_q;
        ir_out_d    = ir_out_q;
        valid_out_d = valid_out_q;
        hold_pc_d   = hold_pc_q;
        hold_ir_d   = hold_ir_q;

        if (redirect_valid) begin
            // Redirect beats stall: the F/D latch must see a bubble next cycle.
            pc_d        = redirect_pc;
            ir_out_d    = NOP;
            valid_out_d = 1'b0;
            hold_pc_d   = '0;
            hold_ir_d   = NOP;
            // A request still in flight must be drained before refetching;
            // a response arriving right now is simply dropped.
            if ((state_q == ST_WAIT || state_q == ST_DISCARD) && !imem_rvalid)
                state_d = ST_DISCARD;
            else
                state_d = ST_IDLE;
        end else begin
            // Bubble whenever the latch is advancing and nothing new is loaded.
            if (!stall_in) begin
                ir_out_d    = NOP;
                valid_out_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_inc;
                        // An empty output register may be filled even under stall.
                        if (!stall_in || !valid_out_q) begin
                            pc_out_d    = pc_inc;
                            ir_out_d    = imem_rdata;
                            valid_out_d = 1'b1;
                            imem_req_d  = 1'b1;
                            imem_addr_d = pc_inc;
                        end else begin
                            hold_pc_d = pc_inc;
                            hold_ir_d = imem_rdata;
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_in) begin
                        pc_out_d    = hold_pc_q;
                        ir_out_d    = hold_ir_q;
                        valid_out_d = 1'b1;
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_q;
                        state_d     = ST_WAIT;
                    end
                end
                default: begin
                    if (imem_rvalid)
                        state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            pc_out_q    <= '0;
            ir_out_q    <= NOP;
            valid_out_q <= 1'b0;
            hold_pc_q   <= '0;
            hold_ir_q   <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            pc_out_q    <= pc_out_d;
            ir_out_q    <= ir_out_d;
            valid_out_q <= valid_out_d;
            hold_pc_q   <= hold_pc_d;
            hold_ir_q   <= hold_ir_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign pc_out    = pc_out_q;
    assign ir_out    = ir_out_q;
    assign valid_out = valid_out_q;

`ifdef FETCH_PERF_CNT_EN
    logic       fetched_inc;
    logic       drop_resp;
    logic       flush_out;
    logic       flush_hold;
    logic [1:0] discarded_inc;

    // Count each instruction once, when it leaves memory; HOLD -> output is a move.
    assign fetched_inc   = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign drop_resp     = imem_rvalid &&
                           ((state_q == ST_DISCARD) || (redirect_valid && state_q == ST_WAIT));
    assign flush_out     = redirect_valid && valid_out_q;
    assign flush_hold    = redirect_valid && (state_q == ST_HOLD);
    assign discarded_inc = {1'b0, drop_resp} + {1'b0, flush_out} + {1'b0, flush_hold};

    fetch_perf_cnt u_perf_cnt (
        .clk            (clk),
        .reset          (reset),
        .fetched_inc    (fetched_inc),
        .discarded_inc  (discarded_inc),
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] ir_out;
    logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded),
`endif
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .ir_out         (ir_out),
        .valid_out      (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdv, input logic [31:0] rpc);
        imem_rvalid    = rv;
        imem_rdata     = rd;
        stall_in       = st;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",   imem_req,  32'd0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_pc",    pc_out,    32'h0);
        check_eq("rst_ir",    ir_out,    32'h0);
        check_eq("rst_valid", valid_out, 32'd0);
        reset = 1'b0;

        // First fetch after reset, one-cycle memory.
        cyc(0, 0, 0, 0, 0);
        check_eq("a_req",   imem_req,  32'd1);
        check_eq("a_addr",  imem_addr, 32'h0);
        check_eq("a_valid", valid_out, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check_eq("a_req_pulse", imem_req, 32'd0);
        cyc(1, 32'hA000_0001, 0, 0, 0);
        check_eq("a_pc",    pc_out,    32'h1);
        check_eq("a_ir",    ir_out,    32'hA000_0001);
        check_eq("a_valid1", valid_out, 32'd1);
        check_eq("a_req2",  imem_req,  32'd1);
        check_eq("a_addr2", imem_addr, 32'h1);

        // Stall for three cycles while the next response lands.
        cyc(0, 0, 1, 0, 0);
        check_eq("b_frz_ir", ir_out,   32'hA000_0001);
        check_eq("b_req0",   imem_req, 32'd0);
        cyc(1, 32'h0000_00B0, 1, 0, 0);
        check_eq("b_hold_ir",    ir_out,    32'hA000_0001);
        check_eq("b_hold_valid", valid_out, 32'd1);
        check_eq("b_hold_noreq", imem_req,  32'd0);
        cyc(0, 0, 1, 0, 0);
        check_eq("b_hold2_pc",  pc_out,   32'h1);
        check_eq("b_hold2_req", imem_req, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check_eq("b_rel_pc",    pc_out,    32'h2);
        check_eq("b_rel_ir",    ir_out,    32'h0000_00B0);
        check_eq("b_rel_valid", valid_out, 32'd1);
        check_eq("b_rel_req",   imem_req,  32'd1);
        check_eq("b_rel_addr",  imem_addr, 32'h2);

        // Redirect while a request is outstanding; response comes two cycles later.
        cyc(0, 0, 0, 1, 32'h40);
        check_eq("c_valid", valid_out, 32'd0);
        check_eq("c_ir",    ir_out,    32'h0);
        check_eq("c_pc",    pc_out,    32'h2);
        check_eq("c_req",   imem_req,  32'd0);
        cyc(0, 0, 0, 0, 0);
        check_eq("c_wait_req", imem_req, 32'd0);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        check_eq("c_drop_valid", valid_out, 32'd0);
        check_eq("c_drop_ir",    ir_out,    32'h0);
        check_eq("c_drop_req",   imem_req,  32'd0);
        cyc(0, 0, 0, 0, 0);
        check_eq("c_new_req",  imem_req,  32'd1);
        check_eq("c_new_addr", imem_addr, 32'h40);

        // Redirect under stall with a valid output: flush wins.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h0000_00C1, 0, 0, 0);
        check_eq("d_pc",    pc_out,    32'h41);
        check_eq("d_valid", valid_out, 32'd1);
        check_eq("d_addr",  imem_addr, 32'h41);
        cyc(0, 0, 1, 1, 32'hFFFF_FFFF);
        check_eq("d_flush_valid", valid_out, 32'd0);
        check_eq("d_flush_ir",    ir_out,    32'h0);
        check_eq("d_flush_pc",    pc_out,    32'h41);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        check_eq("d_disc_req", imem_req, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check_eq("d_new_req",  imem_req,  32'd1);
        check_eq("d_new_addr", imem_addr, 32'hFFFF_FFFF);

        // PC wrap at the top of the address space.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h0000_00E5, 0, 0, 0);
        check_eq("e_pc",    pc_out,    32'h0);
        check_eq("e_ir",    ir_out,    32'h0000_00E5);
        check_eq("e_valid", valid_out, 32'd1);
        check_eq("e_addr",  imem_addr, 32'h0);

        // Redirect coincident with a response: straight back to IDLE.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h100);
        check_eq("f_valid", valid_out, 32'd0);
        check_eq("f_req",   imem_req,  32'd0);
        cyc(0, 0, 0, 0, 0);
        check_eq("f_new_req",  imem_req,  32'd1);
        check_eq("f_new_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched_a",   perf_fetched,   32'd4);
        check_eq("perf_discarded_a", perf_discarded, 32'd5);
`endif

        // Asynchronous reset mid-request, then a late response in IDLE.
        #2 reset = 1'b1;
        #1;
        check_eq("g_async_req",   imem_req,  32'd0);
        check_eq("g_async_addr",  imem_addr, 32'h0);
        check_eq("g_async_pc",    pc_out,    32'h0);
        check_eq("g_async_valid", valid_out, 32'd0);
        #1 reset = 1'b0;
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        check_eq("g_req",   imem_req,  32'd1);
        check_eq("g_addr",  imem_addr, 32'h0);
        check_eq("g_valid", valid_out, 32'd0);
        check_eq("g_ir",    ir_out,    32'h0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched_rst",   perf_fetched,   32'd0);
        check_eq("perf_discarded_rst", perf_discarded, 32'd0);
`endif
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'hA000_0001, 0, 0, 0);
        check_eq("g_pc",     pc_out,    32'h1);
        check_eq("g_valid1", valid_out, 32'd1);

        // Four more back-to-back fetches, then one response dropped by redirect.
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            cyc(1, 32'hF000_0000 + i, 0, 0, 0);
            check_eq("h_pc", pc_out, i + 1);
            check_eq("h_ir", ir_out, 32'hF000_0000 + i);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h0);
        check_eq("h_drop_valid", valid_out, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched_b",   perf_fetched,   32'd5);
        check_eq("perf_discarded_b", perf_discarded, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the F/D pipeline latch. Owns the fetch PC, issues one-outstanding-request reads to instruction memory, and presents {PC+1, instruction, valid} to the F/D latch. Absorbs hazard stalls with a one-entry hold buffer and honours branch/jump redirects from execute, discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP, 32'h0000_0000, instruction word driven on bubbles/flushes
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall_in  in  1  hazard stall; F/D latch holding, output must not change
- redirect_valid  in  1  branch/jump taken in execute
- redirect_pc  in  32  new fetch address when redirect_valid
- imem_req  out  1  registered one-cycle request pulse
- imem_addr  out  32  word address of request, valid with imem_req
- imem_rvalid  in  1  response strobe, ≥1 cycle after imem_req, exactly one per request
- imem_rdata  in  32  instruction, valid with imem_rvalid
- pc_out  out  32  fetched PC+1, to F/D pc_in
- ir_out  out  32  instruction or NOP, to F/D ir_in
- valid_out  out  1  ir_out is a real instruction

## Operation
- Registers: pc_q (address of outstanding/next request), state, output reg {pc_out, ir_out, valid_out}, hold reg {hold_pc, hold_ir}.
- Reset values: state=IDLE, pc_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, pc_out=0, ir_out=NOP, valid_out=0, hold cleared.
- IDLE: next edge imem_req<=1, imem_addr<=pc_q; →WAIT.
- WAIT, imem_rvalid=1:
  - stall_in=0 or valid_out=0: output reg <= {pc_q+1, imem_rdata, 1}; pc_q<=pc_q+1; imem_req<=1 with addr pc_q+1; stay WAIT.
  - stall_in=1 and valid_out=1: hold reg <= {pc_q+1, imem_rdata}; pc_q<=pc_q+1; no request; →HOLD.
- WAIT, no rvalid, stall_in=0: output reg <= {pc_out, NOP, 0} (bubble).
- HOLD: stays while stall_in=1; on stall_in=0 output reg <= {hold_pc, hold_ir, 1}, request pc_q, →WAIT.
- DISCARD: wait for imem_rvalid, drop data, →IDLE; output reg bubbles while stall_in=0.
- Any state, stall_in=1 (no redirect): output reg unchanged.
- Redirect (highest priority, overrides stall_in): pc_q<=redirect_pc; output reg <= {pc_out, NOP, 0}; hold cleared; imem_req<=0. Next state: DISCARD if in WAIT/DISCARD and no imem_rvalid this cycle; else IDLE.
- PC arithmetic: 32-bit, pc_q+1 wraps 32'hFFFF_FFFF→0.

## Timing
- imem_req is a single-cycle pulse; never two requests outstanding.
- 1-cycle memory latency: request at t, rvalid t+1, valid_out t+2, next request t+2 → one instruction per 2 cycles.
- Redirect at t: valid_out=0 at t+1; with nothing outstanding, imem_req=1 at imem_addr=redirect_pc at t+2.
- Redirect coincident with rvalid: response dropped, →IDLE (no DISCARD).
- Reset mid-request: all state cleared asynchronously; a late rvalid arriving in IDLE is ignored.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (+1 per instruction loaded into output or hold reg) and perf_discarded[31:0] (+1 per response dropped, +1 per valid output/hold entry flushed by redirect); both reset to 0, wrap modulo 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- fetch_pkg: state typedef (IDLE, WAIT, HOLD, DISCARD), default NOP and RESET_PC constants.
- Sub-module fetch_perf_cnt (two 32-bit counters) instantiated only under FETCH_PERF_CNT_EN; rest is flat.

## Test plan
- Reset release, 1-cycle imem returning 32'hA000_0001 at 0 → imem_req at addr 0, then pc_out=1, ir_out=32'hA000_0001, valid_out=1; next request addr 1.
- stall_in=1 for 3 cycles while response 32'hB0 arrives with valid_out=1 → output frozen, HOLD entered, no imem_req; stall drop → ir_out=32'hB0 next cycle, request resumes.
- redirect_valid with redirect_pc=32'h40 while request outstanding (rvalid 2 cycles later) → stale response dropped, valid_out=0, next imem_addr=32'h40.
- redirect_valid with stall_in=1 and valid_out=1 → valid_out=0, ir_out=NOP next cycle despite stall.
- pc_q=32'hFFFF_FFFF fetch → pc_out=0, next imem_addr=0.
- FETCH_PERF_CNT_EN: 5 fetches, 1 redirect-discarded response → perf_fetched=5, perf_discarded=1.
